// File: rtl/stack_cache.sv
// Register-windowed hardware stack: the top DEPTH elements live on chip, older elements
// spill to / fill from memory over a single-word req/ack bus.
module stack_cache #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned SP_W      = 15,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_dat,
    input  logic                       i_set_sp,
    input  logic [SP_W-1:0]            i_sp,
    output logic [WIDTH-1:0]           o_top,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [SP_W-1:0]            o_sp,
    output logic                       o_busy,
    output logic                       o_overflow,
    output logic                       o_underflow,
    output logic                       o_req,
    output logic                       o_rw,
    output logic [15:0]                o_addr,
    output logic [WIDTH-1:0]           o_mdat,
    input  logic [WIDTH-1:0]           i_mdat,
    input  logic                       i_ack
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [SP_W-1:0] SP_MAX   = '1;
    localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StSpill, StFill} state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [SP_W-1:0]  r_sp;
    logic             r_ovf, r_unf;
    logic             r_req, r_rw;
    logic [15:0]      r_addr;
    logic [WIDTH-1:0] r_mdat, r_pend;

    logic          w_idle, w_op;
    logic          w_do_set, w_do_repl, w_do_push, w_do_pop;
    logic          w_spill_start, w_fill_start, w_done;
    logic [IW-1:0] w_top_idx, w_wr_idx, w_repl_idx;

    // Byte address of a memory-resident element, truncated to the 16-bit bus.
    function automatic logic [15:0] elem_addr(input logic [SP_W-1:0] e);
        logic [31:0] a;
        a = 32'(BASE_ADDR) + (32'(e) << 1);
        return a[15:0];
    endfunction

    always_comb begin
        w_idle        = (r_state == StIdle);
        w_op          = w_idle & (i_set_sp | i_push | i_pop);
        w_do_set      = w_idle & i_set_sp;
        w_do_repl     = w_idle & ~i_set_sp & i_push & i_pop;
        w_do_push     = w_idle & ~i_set_sp & i_push & ~i_pop;
        w_do_pop      = w_idle & ~i_set_sp & ~i_push & i_pop;
        w_spill_start = w_do_push & (r_sp != SP_MAX) & (r_count == CNT_FULL);
        w_fill_start  = w_idle & ~w_op & (r_count == '0) & (r_sp != '0);
        w_done        = r_req & i_ack;
        w_top_idx     = IW'(r_count - CW'(1));
        w_wr_idx      = IW'(r_count);
        w_repl_idx    = (r_count == '0) ? '0 : w_top_idx;
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_spill_start)     w_state_next = StSpill;
                else if (w_fill_start) w_state_next = StFill;
            end
            StSpill, StFill: begin
                if (i_ack) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        o_busy      = (r_state != StIdle);
        o_top       = (r_count != '0) ? r_mem[w_top_idx] : '0;
        o_count     = r_count;
        o_sp        = r_sp;
        o_overflow  = r_ovf;
        o_underflow = r_unf;
        o_req       = r_req;
        o_rw        = r_rw;
        o_addr      = r_addr;
        o_mdat      = r_mdat;
    end

    // Datapath: ops only land in idle and acks only complete in busy, so they never collide.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_count <= '0;
            r_sp    <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_req   <= 1'b0;
            r_rw    <= 1'b1;
            r_addr  <= '0;
            r_mdat  <= '0;
            r_pend  <= '0;
        end else begin
            if (w_do_set) begin
                r_sp    <= i_sp;
                r_count <= '0;
            end else if (w_do_repl) begin
                if (r_sp == '0) begin
                    r_unf <= 1'b1;
                end else begin
                    r_mem[w_repl_idx] <= i_dat;
                    if (r_count == '0) r_count <= CW'(1);
                end
            end else if (w_do_push) begin
                if (r_sp == SP_MAX) begin
                    r_ovf <= 1'b1;
                end else if (r_count == CNT_FULL) begin
                    r_pend <= i_dat;
                    r_req  <= 1'b1;
                    r_rw   <= 1'b0;
                    r_addr <= elem_addr(r_sp - SP_W'(DEPTH));
                    r_mdat <= r_mem[0];
                end else begin
                    r_mem[w_wr_idx] <= i_dat;
                    r_count         <= r_count + CW'(1);
                    r_sp            <= r_sp + SP_W'(1);
                end
            end else if (w_do_pop) begin
                if (r_count != '0) begin
                    r_count <= r_count - CW'(1);
                    r_sp    <= r_sp - SP_W'(1);
                end else if (r_sp != '0) begin
                    r_sp <= r_sp - SP_W'(1);
                end else begin
                    r_unf <= 1'b1;
                end
            end else if (w_fill_start) begin
                r_req  <= 1'b1;
                r_rw   <= 1'b1;
                r_addr <= elem_addr(r_sp - SP_W'(1));
            end

            if (w_done) begin
                r_req <= 1'b0;
                if (r_state == StSpill) begin
                    for (int i = 0; i < int'(DEPTH) - 1; i++) r_mem[i] <= r_mem[i+1];
                    r_mem[DEPTH-1] <= r_pend;
                    r_sp           <= r_sp + SP_W'(1);
                end else begin
                    r_mem[0] <= i_mdat;
                    r_count  <= CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_stack_cache.sv
// Directed bench for stack_cache: a DEPTH=8/BASE=0x8000 instance for spill/fill work and a
// SP_W=3 instance for overflow and set_sp precedence.
module tb_stack_cache;
    logic        clk = 1'b0;
    logic        reset;
    logic        push, pop, set_sp, ack;
    logic [15:0] dat, mdat;
    logic [14:0] sp_in;
    logic [15:0] top, addr, mdat_o;
    logic [3:0]  count;
    logic [14:0] sp;
    logic        busy, ovf, unf, req, rw;

    logic        s_push, s_pop, s_set_sp, s_ack;
    logic [2:0]  s_sp_in;
    logic [15:0] s_top, s_addr, s_mdat_o;
    logic [3:0]  s_count;
    logic [2:0]  s_sp;
    logic        s_busy, s_ovf, s_unf, s_req, s_rw;

    int checks = 0;
    int failures = 0;
    int req_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) if (req) req_seen++;

    stack_cache #(.WIDTH(16), .DEPTH(8), .SP_W(15), .BASE_ADDR(16'h8000)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_push(push), .i_pop(pop), .i_dat(dat),
        .i_set_sp(set_sp), .i_sp(sp_in), .o_top(top), .o_count(count), .o_sp(sp),
        .o_busy(busy), .o_overflow(ovf), .o_underflow(unf), .o_req(req), .o_rw(rw),
        .o_addr(addr), .o_mdat(mdat_o), .i_mdat(mdat), .i_ack(ack)
    );

    stack_cache #(.WIDTH(16), .DEPTH(8), .SP_W(3), .BASE_ADDR(16'h0000)) u_small (
        .i_clk(clk), .i_reset(reset), .i_push(s_push), .i_pop(s_pop), .i_dat(dat),
        .i_set_sp(s_set_sp), .i_sp(s_sp_in), .o_top(s_top), .o_count(s_count), .o_sp(s_sp),
        .o_busy(s_busy), .o_overflow(s_ovf), .o_underflow(s_unf), .o_req(s_req), .o_rw(s_rw),
        .o_addr(s_addr), .o_mdat(s_mdat_o), .i_mdat(mdat), .i_ack(s_ack)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; push = 0; pop = 0; set_sp = 0; ack = 0; dat = '0; mdat = '0; sp_in = '0;
        s_push = 0; s_pop = 0; s_set_sp = 0; s_ack = 0; s_sp_in = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_top", 32'(top), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_sp", 32'(sp), 0);
        chk("rst_req", 32'(req), 0);
        chk("rst_rw", 32'(rw), 1);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_mdat", 32'(mdat_o), 0);
        chk("rst_flags", {busy, ovf, unf}, 0);

        // Basic push/pop
        push = 1; dat = 16'h1111; step();
        dat = 16'h2222; step();
        dat = 16'h3333; step();
        chk("push3_top", 32'(top), 32'h3333);
        push = 0; pop = 1; step();
        pop = 0;
        chk("pop_top", 32'(top), 32'h2222);
        chk("pop_count", 32'(count), 2);
        chk("pop_sp", 32'(sp), 2);
        chk("basic_no_req", req_seen, 0);

        // Spill: fill window with 1..8, then push 9 with ack three cycles later
        set_sp = 1; sp_in = '0; step();
        set_sp = 0;
        push = 1;
        for (int i = 1; i <= 8; i++) begin
            dat = 16'(i); step();
        end
        chk("full_count", 32'(count), 8);
        dat = 16'h0009; step();
        chk("spill_req", 32'(req), 1);
        chk("spill_rw", 32'(rw), 0);
        chk("spill_addr", 32'(addr), 32'h8000);
        chk("spill_mdat", 32'(mdat_o), 1);
        chk("spill_busy", 32'(busy), 1);
        dat = 16'h00aa; step();
        chk("spill_busy2", 32'(busy), 1);
        step();
        chk("spill_busy3", 32'(busy), 1);
        push = 0; ack = 1; step();
        ack = 0;
        chk("spill_done_busy", {busy, req}, 0);
        chk("spill_top", 32'(top), 9);
        chk("spill_count", 32'(count), 8);
        chk("spill_sp", 32'(sp), 9);

        // Fill: drain window, auto-fill element 0
        pop = 1;
        for (int i = 0; i < 8; i++) step();
        pop = 0;
        chk("drain_count", 32'(count), 0);
        chk("drain_sp", 32'(sp), 1);
        step();
        chk("fill_req", {busy, req, rw}, 3'b111);
        chk("fill_addr", 32'(addr), 32'h8000);
        mdat = 16'h0001; ack = 1; step();
        ack = 0;
        chk("fill_top", 32'(top), 1);
        chk("fill_count", 32'(count), 1);
        chk("fill_sp", 32'(sp), 1);
        chk("fill_idle", {busy, req}, 0);

        // Pop on empty window beats the fill
        set_sp = 1; sp_in = 15'd5; step();
        set_sp = 0; pop = 1; req_seen = 0; step();
        pop = 0;
        chk("epop_sp", 32'(sp), 4);
        chk("epop_count", 32'(count), 0);
        chk("epop_no_req", req_seen + 32'(req), 0);
        step();
        chk("efill_addr", 32'(addr), 32'h8006);
        chk("efill_req", 32'(req), 1);
        mdat = 16'h4444; ack = 1; step();
        ack = 0;
        chk("efill_top", 32'(top), 32'h4444);
        chk("efill_sp", 32'(sp), 4);

        // Replace at sp=0
        set_sp = 1; sp_in = '0; step();
        set_sp = 0; push = 1; pop = 1; dat = 16'h0055; step();
        push = 0; pop = 0;
        chk("repl0_unf", 32'(unf), 1);
        chk("repl0_state", {sp, count, busy, ovf}, 0);

        // set_sp wins over push
        set_sp = 1; sp_in = 15'd3; push = 1; dat = 16'h0077; step();
        set_sp = 0; push = 0;
        chk("prec_sp", 32'(sp), 3);
        chk("prec_count", 32'(count), 0);
        step();
        mdat = 16'h0303; ack = 1; step();
        ack = 0;
        chk("prec_fill_top", 32'(top), 32'h0303);

        // Reset during spill
        push = 1;
        for (int i = 0; i < 7; i++) begin
            dat = 16'(16'h0100 + i); step();
        end
        chk("rs_full", 32'(count), 8);
        step();
        push = 0;
        chk("rs_req", 32'(req), 1);
        reset = 1; step();
        reset = 0;
        chk("rs_req_low", 32'(req), 0);
        chk("rs_sp", 32'(sp), 0);
        chk("rs_count", 32'(count), 0);
        chk("rs_flags", {busy, ovf, unf}, 0);
        ack = 1; step();
        ack = 0; step();
        chk("rs_ack_ignored", {sp, count, busy, req}, 0);
        chk("rs_top", 32'(top), 0);

        // Overflow on the SP_W=3 instance
        s_push = 1;
        for (int i = 0; i < 7; i++) begin
            dat = 16'(16'h0a00 + i); step();
        end
        chk("s_sp7", 32'(s_sp), 7);
        chk("s_ovf_pre", 32'(s_ovf), 0);
        dat = 16'h0bbb; step();
        s_push = 0;
        chk("s_ovf", 32'(s_ovf), 1);
        chk("s_ovf_sp", 32'(s_sp), 7);
        chk("s_ovf_top", 32'(s_top), 32'h0a06);
        s_set_sp = 1; s_sp_in = 3'd2; s_push = 1; step();
        s_set_sp = 0; s_push = 0;
        chk("s_prec_sp", 32'(s_sp), 2);
        chk("s_prec_count", 32'(s_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stack_cache.md
# stack_cache

Parametrised hardware stack for the dcpu family: keeps the top `DEPTH` entries of a data or return stack in registers and spills to / fills from main memory over a single-word request/acknowledge bus. The core sees a zero-wait push/pop/replace port; memory traffic happens only on overflow of the on-chip window or when the window runs dry. One instance serves the data stack, a second the return stack. Both instances share the memory arbiter with the core bus.

## Interface
Parameters:
- `WIDTH`, 16, data word width.
- `DEPTH`, 8, on-chip entries (≥2).
- `SP_W`, 15, stack-pointer width in elements.
- `BASE_ADDR`, 16'h0000, byte address of element 0.

Ports:
- `i_clk` in 1: clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_push` in 1: push `i_dat`; with `i_pop`, replaces the top.
- `i_pop` in 1: pop the top.
- `i_dat` in WIDTH: push data.
- `i_set_sp` in 1: load `i_sp` and flush the on-chip window; has priority over push/pop.
- `i_sp` in SP_W: new element count.
- `o_top` out WIDTH: top of stack; valid when `o_count`≠0.
- `o_count` out $clog2(DEPTH+1): number of on-chip entries.
- `o_sp` out SP_W: total element count.
- `o_busy` out 1: ops ignored while high.
- `o_overflow` out 1: sticky; push attempted with `o_sp`=2^SP_W−1.
- `o_underflow` out 1: sticky; pop or replace attempted with `o_sp`=0.
- `o_req` out 1: memory request.
- `o_rw` out 1: 1=read, 0=write.
- `o_addr` out 16: byte address = BASE_ADDR + {element, 1'b0}, truncated to 16 bits.
- `o_mdat` out WIDTH: write data.
- `i_mdat` in WIDTH: read data, sampled with ack.
- `i_ack` in 1: completes the request in the cycle it is high.

## Operation
- **Storage.** On-chip entries hold elements `sp−count … sp−1`. Memory holds elements `0 … sp−count−1`.
- **States.** IDLE, SPILL, FILL. `o_busy` = (state≠IDLE).
- **Op acceptance.** Ops are accepted only in IDLE, at the clock edge.
- **Op precedence.** set_sp > replace (push & pop) > push > pop.
- **set_sp.**
  - sp←`i_sp`, count←0.
  - On-chip contents are discarded; there is no write-back.
- **push, count<DEPTH.** Entry written; count+1, sp+1.
- **push, count=DEPTH.**
  - `i_dat` is latched; state→SPILL.
  - Spill request: `o_req`=1, `o_rw`=0, `o_addr` of element sp−DEPTH, `o_mdat` = oldest entry.
  - On ack: oldest entry dropped, latched data pushed; count stays DEPTH, sp+1; state→IDLE.
- **pop.**
  - count>0: count−1, sp−1.
  - count=0, sp>0: sp−1 only; no memory access.
  - sp=0: no change; `o_underflow`←1.
- **replace.**
  - sp>0: top←`i_dat`; count←max(count,1); sp unchanged.
  - sp=0: no change; `o_underflow`←1.
- **push at sp=2^SP_W−1.** No change; `o_overflow`←1. No wrap.
- **Auto-fill.**
  - Trigger: in IDLE with count=0, sp>0 and no op accepted this cycle → state→FILL.
  - Fill request: `o_req`=1, `o_rw`=1, address of element sp−1.
  - On ack: the entry ← `i_mdat`, count←1; state→IDLE.
- **Op vs. fill start.** An op presented in the same cycle the fill would start wins; the fill re-evaluates next cycle.
- **Bus outputs.** `o_req/o_rw/o_addr/o_mdat` are registered and stable for the whole request.
- **Reset values.**
  - state IDLE, sp 0, count 0.
  - `o_req` 0, `o_rw` 1, `o_addr` 0, `o_mdat` 0, `o_top` 0.
  - Both sticky flags 0.
- **Reset mid-request.** The request is abandoned, and `o_req` is low from the cycle after the reset edge. The arbiter must tolerate a dropped request.

## Timing
- **IDLE push/pop/replace/set_sp.** Results (`o_top`, `o_count`, `o_sp`, flags) are visible the cycle after the accepting edge.
- **Spill.**
  - Accepted at edge E0; `o_req`, `o_busy` high from E0.
  - Ack sampled at edge En (n≥1): `o_req`, `o_busy` low and new top visible after En.
  - Minimum `o_busy` duration: 1 cycle.
- **Fill.** Same timing as spill. Minimum: 1 busy cycle after the decision edge.
- **Ignored inputs.** Ops while `o_busy` are ignored with no effect (not queued). Requesters hold ops until `o_busy` is low.
- **Ack while idle.** `i_ack` with `o_req` low is ignored.

## Test plan
- **Basic push/pop.** Reset, push 0x1111, 0x2222, 0x3333, pop → `o_top`=0x2222, count=2, sp=2, `o_req` never asserted.
- **Spill.** DEPTH=8, BASE=0x8000: push 1..8, then push 9 with ack delayed 3 cycles.
  - `o_req`/`o_rw`=0, `o_addr`=0x8000, `o_mdat`=1, busy 3 cycles.
  - After ack: top=9, count=8, sp=9.
  - A push presented while busy is ignored.
- **Fill.** From the spill state above, pop 8 times → count=0, sp=1.
  - Auto-fill reads 0x8000; return 0x0001 → top=1, count=1, sp=1.
- **Pop/replace on empty window.**
  - set_sp 5, then pop immediately → sp=4, no memory access.
  - Fill address = BASE+6.
  - Replace at sp=0 → `o_underflow`=1, state unchanged.
- **Overflow and precedence.**
  - SP_W=3, push 7 times, then push again → `o_overflow`=1, sp=7.
  - set_sp with simultaneous push → sp=`i_sp`, count=0.
- **Reset during spill.** Reset while `o_req` is high → `o_req`=0 next cycle, sp=0, count=0, flags clear.
  - A later ack pulse has no effect.
